// File: rtl/avalon_pio_gpio_if.sv
// Avalon-MM slave bus bundle for the GPIO port: register select, write strobe and read data.
interface avalon_pio_gpio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_gpio.sv
// Parametrised Avalon-MM GPIO port: per-bit direction, optional open-drain drive,
// two-flop input synchroniser, edge capture with warm-up suppression and maskable irq.
module avalon_pio_gpio #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned           OPEN_DRAIN  = 0,
  parameter int unsigned           EDGE_TYPE   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  avalon_pio_gpio_if.slave         bus,
  input  logic [WIDTH-1:0]         pin_in,
  output logic [WIDTH-1:0]         pin_out,
  output logic [WIDTH-1:0]         pin_oe,
  output logic                     irq
);

  localparam int unsigned BUS_W     = 32;
  localparam logic [2:0]  ADDR_DATA = 3'd0;
  localparam logic [2:0]  ADDR_DIR  = 3'd1;
  localparam logic [2:0]  ADDR_MASK = 3'd2;
  localparam logic [2:0]  ADDR_CAP  = 3'd3;
  localparam logic [2:0]  ADDR_SET  = 3'd4;
  localparam logic [2:0]  ADDR_CLR  = 3'd5;
  localparam logic [1:0]  WARM_DONE = 2'd3;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sync3;
  logic [1:0]       r_warm;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_data_next;
  logic [WIDTH-1:0] w_cap_clr;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_det;
  logic             w_unused_wdata;

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_wdata = bus.writedata[WIDTH-1:0];
  // Bits of writedata above WIDTH carry no meaning for this port.
  assign w_unused_wdata = ^bus.writedata;

  // Next output-data value from DATA / OUTSET / OUTCLR writes.
  always_comb begin
    w_data_next = r_data_out;
    if (w_wr) begin
      case (bus.address)
        ADDR_DATA: w_data_next = w_wdata;
        ADDR_SET:  w_data_next = r_data_out | w_wdata;
        ADDR_CLR:  w_data_next = r_data_out & ~w_wdata;
        default:   w_data_next = r_data_out;
      endcase
    end
  end

  // Edge detection on the synchronised inputs, gated until the warm-up counter saturates.
  always_comb begin
    w_rise = r_sync2 & ~r_sync3;
    w_fall = ~r_sync2 & r_sync3;
    case (EDGE_TYPE)
      0:       w_det = w_rise;
      1:       w_det = w_fall;
      default: w_det = w_rise | w_fall;
    endcase
    if (r_warm != WARM_DONE) begin
      w_det = '0;
    end
  end

  assign w_cap_clr = (w_wr && (bus.address == ADDR_CAP)) ? w_wdata : '0;

  // Control registers; reset overrides any bus write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= '0;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
    end else begin
      r_data_out <= w_data_next;
      if (w_wr && (bus.address == ADDR_DIR)) begin
        r_dir <= w_wdata;
      end
      if (w_wr && (bus.address == ADDR_MASK)) begin
        r_irq_mask <= w_wdata;
      end
      // A detection in the same cycle as write-1-to-clear keeps the bit set.
      r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_det;
    end
  end

  // Input synchroniser chain plus previous-value stage and warm-up counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_warm  <= 2'd0;
    end else begin
      r_sync1 <= pin_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (r_warm != WARM_DONE) begin
        r_warm <= r_warm + 2'd1;
      end
    end
  end

  // Zero-wait-state read mux; unused upper bits and write-only/reserved addresses read 0.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA: bus.readdata = BUS_W'(r_sync2);
      ADDR_DIR:  bus.readdata = BUS_W'(r_dir);
      ADDR_MASK: bus.readdata = BUS_W'(r_irq_mask);
      ADDR_CAP:  bus.readdata = BUS_W'(r_edge_cap);
      default:   bus.readdata = '0;
    endcase
  end

  // Pin drive: open-drain only ever pulls low where dir=1 and data=0.
  generate
    if (OPEN_DRAIN != 0) begin : g_open_drain
      assign pin_out = '0;
      assign pin_oe  = r_dir & ~r_data_out;
    end else begin : g_push_pull
      assign pin_out = r_data_out;
      assign pin_oe  = r_dir;
    end
  endgenerate

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Directed bench for avalon_pio_gpio: push-pull instance (RESET_VALUE A5, rising edges)
// and an open-drain instance sharing clock, reset and pins.
module tb_avalon_pio_gpio;

  logic       clk;
  logic       reset;
  logic [7:0] pin_in;
  logic [7:0] pp_pin_out, pp_pin_oe;
  logic [7:0] od_pin_out, od_pin_oe;
  logic       pp_irq, od_irq;
  int         errors;
  int         checks;

  avalon_pio_gpio_if bus_pp ();
  avalon_pio_gpio_if bus_od ();

  avalon_pio_gpio #(.WIDTH(8), .RESET_VALUE(8'hA5), .OPEN_DRAIN(0), .EDGE_TYPE(0)) u_pp (
    .clk(clk), .reset(reset), .bus(bus_pp.slave), .pin_in(pin_in),
    .pin_out(pp_pin_out), .pin_oe(pp_pin_oe), .irq(pp_irq)
  );

  avalon_pio_gpio #(.WIDTH(8), .RESET_VALUE(8'h00), .OPEN_DRAIN(1), .EDGE_TYPE(0)) u_od (
    .clk(clk), .reset(reset), .bus(bus_od.slave), .pin_in(pin_in),
    .pin_out(od_pin_out), .pin_oe(od_pin_oe), .irq(od_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle write on the push-pull bus; returns just after the write edge.
  task automatic wr_pp(input logic [2:0] a, input logic [31:0] d);
    bus_pp.address = a; bus_pp.writedata = d; bus_pp.chipselect = 1'b1; bus_pp.write_n = 1'b0;
    tick();
    bus_pp.chipselect = 1'b0; bus_pp.write_n = 1'b1;
  endtask

  task automatic wr_od(input logic [2:0] a, input logic [31:0] d);
    bus_od.address = a; bus_od.writedata = d; bus_od.chipselect = 1'b1; bus_od.write_n = 1'b0;
    tick();
    bus_od.chipselect = 1'b0; bus_od.write_n = 1'b1;
  endtask

  task automatic test_reset();
    pin_in = 8'hFF;
    reset  = 1'b1;
    repeat (3) tick();
    checks++; if (pp_pin_out !== 8'hA5) begin errors++; $display("FAIL reset_pin_out got=%h exp=a5", pp_pin_out); end
    checks++; if (pp_pin_oe !== 8'h00) begin errors++; $display("FAIL reset_pin_oe got=%h exp=00", pp_pin_oe); end
    checks++; if (pp_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", pp_irq); end
    checks++; if (od_pin_out !== 8'h00) begin errors++; $display("FAIL reset_od_pin_out got=%h exp=00", od_pin_out); end
    bus_pp.address = 3'd0; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL reset_data_read got=%h exp=0", bus_pp.readdata); end
    bus_pp.address = 3'd1; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL reset_dir_read got=%h exp=0", bus_pp.readdata); end
    bus_pp.address = 3'd2; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL reset_mask_read got=%h exp=0", bus_pp.readdata); end
  endtask

  task automatic test_warmup();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) tick();
    bus_pp.address = 3'd3; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL warmup_edge_cap got=%h exp=0", bus_pp.readdata); end
    checks++; if (pp_irq !== 1'b0) begin errors++; $display("FAIL warmup_irq got=%b exp=0", pp_irq); end
    bus_pp.address = 3'd0; #1;
    checks++; if (bus_pp.readdata !== 32'h000000FF) begin errors++; $display("FAIL warmup_data_read got=%h exp=000000ff", bus_pp.readdata); end
  endtask

  task automatic test_outputs();
    wr_pp(3'd0, 32'hFFFF_FF0F);
    checks++; if (pp_pin_out !== 8'h0F) begin errors++; $display("FAIL data_write got=%h exp=0f", pp_pin_out); end
    wr_pp(3'd4, 32'h0000_0030);
    checks++; if (pp_pin_out !== 8'h3F) begin errors++; $display("FAIL outset got=%h exp=3f", pp_pin_out); end
    wr_pp(3'd5, 32'h0000_0001);
    checks++; if (pp_pin_out !== 8'h3E) begin errors++; $display("FAIL outclr got=%h exp=3e", pp_pin_out); end
    bus_pp.address = 3'd4; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL outset_read got=%h exp=0", bus_pp.readdata); end
    bus_pp.address = 3'd5; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL outclr_read got=%h exp=0", bus_pp.readdata); end
    wr_pp(3'd1, 32'h0000_00C3);
    checks++; if (pp_pin_oe !== 8'hC3) begin errors++; $display("FAIL dir_pin_oe got=%h exp=c3", pp_pin_oe); end
    bus_pp.address = 3'd1; #1;
    checks++; if (bus_pp.readdata !== 32'h000000C3) begin errors++; $display("FAIL dir_read got=%h exp=c3", bus_pp.readdata); end
  endtask

  task automatic test_edge_capture();
    wr_pp(3'd2, 32'h0000_0004);
    // Falling edge on bit 2 is ignored for rising-edge capture.
    pin_in = 8'hFB;
    repeat (4) tick();
    bus_pp.address = 3'd3; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL fall_ignored got=%h exp=0", bus_pp.readdata); end
    // Rising edge on bit 2 before edge N; capture appears after N+2.
    pin_in = 8'hFF;
    tick();
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL cap_after_n got=%h exp=0", bus_pp.readdata); end
    tick();
    checks++; if (pp_irq !== 1'b0) begin errors++; $display("FAIL irq_after_n1 got=%b exp=0", pp_irq); end
    tick();
    checks++; if (bus_pp.readdata !== 32'h4) begin errors++; $display("FAIL cap_after_n2 got=%h exp=4", bus_pp.readdata); end
    checks++; if (pp_irq !== 1'b1) begin errors++; $display("FAIL irq_after_n2 got=%b exp=1", pp_irq); end
    // Mask clear drops irq immediately; restoring it raises irq again.
    wr_pp(3'd2, 32'h0);
    checks++; if (pp_irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", pp_irq); end
    wr_pp(3'd2, 32'h4);
    checks++; if (pp_irq !== 1'b1) begin errors++; $display("FAIL irq_unmasked got=%b exp=1", pp_irq); end
    // Fresh rising edge detected in the same cycle as the clear write: bit stays set.
    pin_in = 8'hFB;
    repeat (4) tick();
    pin_in = 8'hFF;
    tick();
    tick();
    wr_pp(3'd3, 32'h4);
    bus_pp.address = 3'd3; #1;
    checks++; if (bus_pp.readdata !== 32'h4) begin errors++; $display("FAIL clear_vs_detect got=%h exp=4", bus_pp.readdata); end
    checks++; if (pp_irq !== 1'b1) begin errors++; $display("FAIL clear_vs_detect_irq got=%b exp=1", pp_irq); end
    // Clear with no detection pending.
    wr_pp(3'd3, 32'h4);
    bus_pp.address = 3'd3; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL clear got=%h exp=0", bus_pp.readdata); end
    checks++; if (pp_irq !== 1'b0) begin errors++; $display("FAIL clear_irq got=%b exp=0", pp_irq); end
  endtask

  task automatic test_open_drain();
    wr_od(3'd1, 32'hFF);
    wr_od(3'd0, 32'hF0);
    checks++; if (od_pin_out !== 8'h00) begin errors++; $display("FAIL od_pin_out got=%h exp=00", od_pin_out); end
    checks++; if (od_pin_oe !== 8'h0F) begin errors++; $display("FAIL od_pin_oe got=%h exp=0f", od_pin_oe); end
    checks++; if (od_irq !== 1'b0) begin errors++; $display("FAIL od_irq got=%b exp=0", od_irq); end
  endtask

  task automatic test_reset_priority();
    bus_pp.address = 3'd1; bus_pp.writedata = 32'hFF; bus_pp.chipselect = 1'b1; bus_pp.write_n = 1'b0;
    reset = 1'b1;
    tick();
    bus_pp.chipselect = 1'b0; bus_pp.write_n = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL reset_prio_dir got=%h exp=0", bus_pp.readdata); end
    checks++; if (pp_pin_oe !== 8'h00) begin errors++; $display("FAIL reset_prio_oe got=%h exp=00", pp_pin_oe); end
    checks++; if (pp_pin_out !== 8'hA5) begin errors++; $display("FAIL reset_prio_out got=%h exp=a5", pp_pin_out); end
    wr_pp(3'd6, 32'hFF);
    bus_pp.address = 3'd6; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL reserved_read got=%h exp=0", bus_pp.readdata); end
    bus_pp.address = 3'd1; #1;
    checks++; if (bus_pp.readdata !== 32'h0) begin errors++; $display("FAIL reserved_write_dir got=%h exp=0", bus_pp.readdata); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    pin_in = 8'h00;
    bus_pp.address = 3'd0; bus_pp.chipselect = 1'b0; bus_pp.write_n = 1'b1; bus_pp.writedata = 32'h0;
    bus_od.address = 3'd0; bus_od.chipselect = 1'b0; bus_od.write_n = 1'b1; bus_od.writedata = 32'h0;
    test_reset();
    test_warmup();
    test_outputs();
    test_edge_capture();
    test_open_drain();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_pio_gpio.md
# avalon_pio_gpio

Parametrised Avalon-MM general-purpose I/O port. It generalises the single-bit write-only output ports used for bit-banged I2C and LCD control lines to WIDTH bits per instance. Each bit has a direction control, an optional open-drain mode, and synchronised input readback. Input edges are captured per bit and raise a maskable interrupt. The block sits on the Nios II system interconnect as a zero-wait-state slave; its pins go to the top-level board I/O.

## Interface
- WIDTH, 8: number of I/O bits, 1..32.
- RESET_VALUE, 0: reset value of the output data register (WIDTH bits).
- OPEN_DRAIN, 0: 1 selects open-drain drive on all bits, 0 selects push-pull.
- EDGE_TYPE, 0: which input edges are captured; 0 rising, 1 falling, 2 both.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  combinational read data; bits above WIDTH always read 0.
- pin_in  in  WIDTH  asynchronous pin inputs.
- pin_out  out  WIDTH  pin drive value.
- pin_oe  out  WIDTH  per-bit output enable.
- irq  out  1  level interrupt, active high.

## Operation
- A write occurs when chipselect is 1 and write_n is 0. It takes effect at that rising edge of clk.

Register map:
- Address 0, DATA. Write: data_out <= writedata. Read: the synchronised pin state, sync2.
- Address 1, DIR. Read/write. 1 = output.
- Address 2, IRQ_MASK. Read/write.
- Address 3, EDGE_CAP. Read returns the capture bits. Writing 1 to a bit clears it.
- Address 4, OUTSET. Write only: data_out <= data_out | writedata. Reads 0.
- Address 5, OUTCLR. Write only: data_out <= data_out & ~writedata. Reads 0.
- Addresses 6 and 7: reserved. Reads 0; writes are ignored.

Input synchroniser:
- pin_in passes through sync1 then sync2.
- sync3 holds the previous value of sync2 and is used for edge detection.

Edge detection:
- rise = sync2 & ~sync3; fall = ~sync2 & sync3.
- The detected vector is rise, fall, or rise|fall, selected by EDGE_TYPE.
- Warm-up: a 2-bit counter starts at 0 on reset and saturates at 3. Edge detection is suppressed while the counter is below 3. This prevents pins that are high at reset from producing false captures.
- If detection and a write-1-to-clear hit the same bit in the same cycle, detection wins and the bit stays 1.

Outputs:
- Push-pull: pin_out = data_out; pin_oe = dir.
- Open-drain: pin_out = 0; pin_oe = dir & ~data_out. A bit is driven low only when dir = 1 and data_out = 0.
- irq = |(edge_cap & irq_mask), combinational.

Reset (while reset = 1 at a rising edge):
- data_out <= RESET_VALUE.
- dir, irq_mask, edge_cap, sync1, sync2, sync3 and the warm-up counter all <= 0.
- Reset takes priority over a simultaneous bus write.
- Resulting outputs: pin_oe = 0, irq = 0, pin_out = RESET_VALUE (0 in open-drain mode), readdata at address 0 = 0.

## Timing
- Read: zero wait states. readdata is valid in the same cycle that address is presented.
- Write: a register takes its new value at edge N and is visible on the pins and readdata after edge N.
- Input readback latency: pin_in stable before edge N is seen in DATA reads after edge N+1.
- Edge capture latency: a transition on pin_in before edge N sets edge_cap at edge N+2, so irq asserts after edge N+2.
- irq deasserts the cycle after the clearing write, or immediately when the mask bit is cleared.
- A pulse narrower than one clk period may be missed. No glitch filtering is provided.

## Test plan
- Reset, WIDTH=8, RESET_VALUE=8'hA5, push-pull -> pin_out = A5, pin_oe = 00, irq = 0; DIR and IRQ_MASK read 0.
- Write DATA = 0F, then OUTSET = 30, then OUTCLR = 01 -> pin_out is 0F, then 3F, then 3E, each one cycle after its write; reads of addresses 4 and 5 return 0.
- Hold pin_in = FF through reset; release reset and wait 5 cycles -> EDGE_CAP = 00 and irq = 0 (warm-up suppression).
- EDGE_TYPE=0, IRQ_MASK = 04, pin_in bit 2 goes 0 -> 1 before edge N -> EDGE_CAP = 04 and irq = 1 after edge N+2.
  - Then write 04 to EDGE_CAP in the same cycle as a fresh detection on bit 2 -> the bit remains set.
  - Then write 04 to EDGE_CAP with no detection -> irq = 0.
- OPEN_DRAIN=1, DIR = FF, DATA = F0 -> pin_out = 00, pin_oe = 0F.
- Assert reset during a write of DIR = FF -> DIR reads 00 afterwards; a read of address 6 returns 0.
